lookup_fib: RTL and testbench

//  IPv4 forwarding-information-base lookup for the router datapath. Each req carries a

---
 rtl/lookup_fib_if.sv | 37 +++
 rtl/lookup_fib.sv | 169 ++++++++++++++++
 tb/tb_lookup_fib.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/lookup_fib_if.sv
// ============================================================================
//  Module   : lookup_fib_if
//  Purpose  : Request/response bundle for the IPv4 FIB lookup block, including
//             the per-interface MAC addresses used to build src_mac.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lookup_fib_if;
   logic        req;
   logic [31:0] search_ip;
   logic [47:0] int_0_mac_addr;
   logic [47:0] int_1_mac_addr;
   logic [47:0] int_2_mac_addr;
   logic [47:0] int_3_mac_addr;
   logic        ack;
   logic [31:0] dest_ip;
   logic [47:0] src_mac;
   logic [47:0] dest_mac;
   logic [3:0]  forward_port;

   // Requester side: issues lookups and supplies interface MACs.
   modport master (
      output req, search_ip,
      output int_0_mac_addr, int_1_mac_addr, int_2_mac_addr, int_3_mac_addr,
      input  ack, dest_ip, src_mac, dest_mac, forward_port
   );

   // Lookup engine side.
   modport slave (
      input  req, search_ip,
      input  int_0_mac_addr, int_1_mac_addr, int_2_mac_addr, int_3_mac_addr,
      output ack, dest_ip, src_mac, dest_mac, forward_port
   );
endinterface

`default_nettype wire

// File: rtl/lookup_fib.sv
// ============================================================================
//  Module   : lookup_fib
//  Purpose  : Two-stage pipelined IPv4 FIB lookup against a fixed ROM. Stage 1
//             captures the address and a per-entry match vector; stage 2
//             priority-encodes it, masks out-of-range ports and registers the
//             egress bitmap, source/next-hop MACs and echoed address.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lookup_fib #(
   parameter logic [3:0] MAX_PORT = 4'h3
) (
   input  wire logic      sys_clk_i,
   input  wire logic      sys_rst_i,
   lookup_fib_if.slave    bus
);

   localparam int C_NUM_ENTRIES = 5;

   // ROM contents, index order is priority order (longest prefixes first).
   function automatic logic [31:0] entry_prefix(input int idx);
      case (idx)
         0:       entry_prefix = 32'h0A00_1469;   // 10.0.20.105
         1:       entry_prefix = 32'h0A00_146A;   // 10.0.20.106
         2:       entry_prefix = 32'h0A00_1569;   // 10.0.21.105
         3:       entry_prefix = 32'h0A00_1400;   // 10.0.20.0
         default: entry_prefix = 32'h0A00_1500;   // 10.0.21.0
      endcase
   endfunction

   function automatic int entry_len(input int idx);
      entry_len = (idx < 3) ? 32 : 24;
   endfunction

   function automatic logic [3:0] entry_port(input int idx);
      case (idx)
         0, 1, 3: entry_port = 4'b0001;
         default: entry_port = 4'b0010;
      endcase
   endfunction

   function automatic logic [47:0] entry_mac(input int idx);
      case (idx)
         0:       entry_mac = 48'h00_11_22_33_44_55;
         1:       entry_mac = 48'h00_11_22_33_44_66;
         2:       entry_mac = 48'h00_11_22_33_44_aa;
         default: entry_mac = 48'hff_ff_ff_ff_ff_ff;
      endcase
   endfunction

   // Only interfaces 0..MAX_PORT exist; higher route bits are dropped.
   function automatic logic [3:0] port_mask();
      logic [3:0] m;
      m = '0;
      for (int i = 0; i < 4; i++) begin
         if (i <= int'(MAX_PORT)) m[i] = 1'b1;
      end
      return m;
   endfunction

   localparam logic [3:0] C_PORT_MASK = port_mask();

   logic [C_NUM_ENTRIES-1:0] match_w;

   logic                     s1_valid_q, s1_valid_d;
   logic [31:0]              s1_ip_q,    s1_ip_d;
   logic [C_NUM_ENTRIES-1:0] s1_match_q, s1_match_d;

   logic        ack_q,      ack_d;
   logic [31:0] dest_ip_q,  dest_ip_d;
   logic [47:0] src_mac_q,  src_mac_d;
   logic [47:0] dest_mac_q, dest_mac_d;
   logic [3:0]  port_q,     port_d;

   logic [3:0]  raw_port_w;
   logic [47:0] raw_mac_w;
   logic [3:0]  port_w;

   // Per-entry prefix compare, evaluated in parallel on the incoming address.
   for (genvar e = 0; e < C_NUM_ENTRIES; e++) begin : g_entry
      localparam logic [31:0] C_MASK = ~(32'hFFFF_FFFF >> entry_len(e));
      assign match_w[e] = ((bus.search_ip & C_MASK) == (entry_prefix(e) & C_MASK));
   end

   // Stage 1 next state: capture address and match vector only with req.
   always_comb begin
      s1_valid_d = bus.req;
      s1_ip_d    = s1_ip_q;
      s1_match_d = s1_match_q;
      if (bus.req) begin
         s1_ip_d    = bus.search_ip;
         s1_match_d = match_w;
      end
   end

   // Stage 1 registers.
   always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
      if (sys_rst_i) begin
         s1_valid_q <= 1'b0;
         s1_ip_q    <= '0;
         s1_match_q <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_ip_q    <= s1_ip_d;
         s1_match_q <= s1_match_d;
      end
   end

   // Priority encode: iterate from lowest priority upward so entry 0 wins.
   always_comb begin
      raw_port_w = '0;
      raw_mac_w  = '0;
      for (int e = C_NUM_ENTRIES - 1; e >= 0; e--) begin
         if (s1_match_q[e]) begin
            raw_port_w = entry_port(e);
            raw_mac_w  = entry_mac(e);
         end
      end
   end

   assign port_w = raw_port_w & C_PORT_MASK;

   // Stage 2 next state: outputs move only when a result is delivered; a
   // bitmap emptied by masking is reported as a miss.
   always_comb begin
      ack_d      = s1_valid_q;
      dest_ip_d  = dest_ip_q;
      src_mac_d  = src_mac_q;
      dest_mac_d = dest_mac_q;
      port_d     = port_q;
      if (s1_valid_q) begin
         dest_ip_d  = s1_ip_q;
         port_d     = port_w;
         dest_mac_d = (port_w == 4'b0000) ? 48'h0 : raw_mac_w;
         if      (port_w[0]) src_mac_d = bus.int_0_mac_addr;
         else if (port_w[1]) src_mac_d = bus.int_1_mac_addr;
         else if (port_w[2]) src_mac_d = bus.int_2_mac_addr;
         else if (port_w[3]) src_mac_d = bus.int_3_mac_addr;
         else                src_mac_d = 48'h0;
      end
   end

   // Stage 2 / output registers.
   always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
      if (sys_rst_i) begin
         ack_q      <= 1'b0;
         dest_ip_q  <= '0;
         src_mac_q  <= '0;
         dest_mac_q <= '0;
         port_q     <= '0;
      end else begin
         ack_q      <= ack_d;
         dest_ip_q  <= dest_ip_d;
         src_mac_q  <= src_mac_d;
         dest_mac_q <= dest_mac_d;
         port_q     <= port_d;
      end
   end

   assign bus.ack          = ack_q;
   assign bus.dest_ip      = dest_ip_q;
   assign bus.src_mac      = src_mac_q;
   assign bus.dest_mac     = dest_mac_q;
   assign bus.forward_port = port_q;

endmodule

`default_nettype wire

// File: tb/tb_lookup_fib.sv
// ============================================================================
//  Module   : tb_lookup_fib
//  Purpose  : Directed self-checking bench for lookup_fib (MAX_PORT=3 main
//             instance, MAX_PORT=0 instance for port masking).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_lookup_fib;
   localparam logic [47:0] C_MAC0 = 48'h00a0de1c07e2;
   localparam logic [47:0] C_MAC1 = 48'h00a0de1c07e8;
   localparam logic [47:0] C_MAC2 = 48'h00a0de1c07f0;
   localparam logic [47:0] C_MAC3 = 48'h00a0de1c07f8;
   localparam logic [47:0] C_BCAST = 48'hffffffffffff;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   lookup_fib_if bus3 ();
   lookup_fib_if bus0 ();

   lookup_fib #(.MAX_PORT(4'h3)) dut  (.sys_clk_i(clk), .sys_rst_i(rst), .bus(bus3.slave));
   lookup_fib #(.MAX_PORT(4'h0)) dut0 (.sys_clk_i(clk), .sys_rst_i(rst), .bus(bus0.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one request pulse on the chosen instance; returns #1 after the
   // sampling edge, with req dropped and search_ip set to junk.
   task automatic pulse_req(input bit use0, input logic [31:0] ip);
      @(posedge clk); #1;
      if (use0) begin bus0.req = 1'b1; bus0.search_ip = ip; end
      else      begin bus3.req = 1'b1; bus3.search_ip = ip; end
      @(posedge clk); #1;
      if (use0) begin bus0.req = 1'b0; bus0.search_ip = 32'hDEAD_BEEF; end
      else      begin bus3.req = 1'b0; bus3.search_ip = 32'hDEAD_BEEF; end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++; if (bus3.ack !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b exp=0", bus3.ack); end
      total++; if (bus3.dest_ip !== 32'h0) begin bad++; $display("FAIL reset_dest_ip got=%h exp=0", bus3.dest_ip); end
      total++; if (bus3.src_mac !== 48'h0) begin bad++; $display("FAIL reset_src_mac got=%h exp=0", bus3.src_mac); end
      total++; if (bus3.dest_mac !== 48'h0) begin bad++; $display("FAIL reset_dest_mac got=%h exp=0", bus3.dest_mac); end
      total++; if (bus3.forward_port !== 4'h0) begin bad++; $display("FAIL reset_port got=%b exp=0000", bus3.forward_port); end
      rst = 1'b0;
   endtask

   task automatic test_subnet();
      pulse_req(1'b0, 32'h0A00_140A);   // 10.0.20.10
      total++; if (bus3.ack !== 1'b0) begin bad++; $display("FAIL subnet_early_ack got=%b exp=0", bus3.ack); end
      @(posedge clk); #1;
      total++; if (bus3.ack !== 1'b1) begin bad++; $display("FAIL subnet_ack got=%b exp=1", bus3.ack); end
      total++; if (bus3.forward_port !== 4'b0001) begin bad++; $display("FAIL subnet_port got=%b exp=0001", bus3.forward_port); end
      total++; if (bus3.src_mac !== C_MAC0) begin bad++; $display("FAIL subnet_src got=%h exp=%h", bus3.src_mac, C_MAC0); end
      total++; if (bus3.dest_mac !== C_BCAST) begin bad++; $display("FAIL subnet_dest got=%h exp=%h", bus3.dest_mac, C_BCAST); end
      total++; if (bus3.dest_ip !== 32'h0A00_140A) begin bad++; $display("FAIL subnet_ip got=%h exp=0a00140a", bus3.dest_ip); end
      @(posedge clk); #1;
      total++; if (bus3.ack !== 1'b0) begin bad++; $display("FAIL subnet_ack_single got=%b exp=0", bus3.ack); end
      total++; if (bus3.dest_mac !== C_BCAST) begin bad++; $display("FAIL subnet_hold got=%h exp=%h", bus3.dest_mac, C_BCAST); end
   endtask

   task automatic test_host();
      pulse_req(1'b0, 32'h0A00_1469);   // 10.0.20.105
      @(posedge clk); #1;
      total++; if (bus3.ack !== 1'b1) begin bad++; $display("FAIL host105_ack got=%b exp=1", bus3.ack); end
      total++; if (bus3.forward_port !== 4'b0001) begin bad++; $display("FAIL host105_port got=%b exp=0001", bus3.forward_port); end
      total++; if (bus3.src_mac !== C_MAC0) begin bad++; $display("FAIL host105_src got=%h exp=%h", bus3.src_mac, C_MAC0); end
      total++; if (bus3.dest_mac !== 48'h001122334455) begin bad++; $display("FAIL host105_dest got=%h exp=001122334455", bus3.dest_mac); end
      pulse_req(1'b0, 32'h0A00_146A);   // 10.0.20.106
      @(posedge clk); #1;
      total++; if (bus3.dest_mac !== 48'h001122334466) begin bad++; $display("FAIL host106_dest got=%h exp=001122334466", bus3.dest_mac); end
      total++; if (bus3.dest_ip !== 32'h0A00_146A) begin bad++; $display("FAIL host106_ip got=%h exp=0a00146a", bus3.dest_ip); end
   endtask

   task automatic test_priority();
      pulse_req(1'b0, 32'h0A00_1569);   // 10.0.21.105, /32 over /24
      @(posedge clk); #1;
      total++; if (bus3.forward_port !== 4'b0010) begin bad++; $display("FAIL prio_port got=%b exp=0010", bus3.forward_port); end
      total++; if (bus3.src_mac !== C_MAC1) begin bad++; $display("FAIL prio_src got=%h exp=%h", bus3.src_mac, C_MAC1); end
      total++; if (bus3.dest_mac !== 48'h0011223344aa) begin bad++; $display("FAIL prio_dest got=%h exp=0011223344aa", bus3.dest_mac); end
      pulse_req(1'b0, 32'h0A00_1501);   // 10.0.21.1 -> /24 only
      @(posedge clk); #1;
      total++; if (bus3.dest_mac !== C_BCAST) begin bad++; $display("FAIL net21_dest got=%h exp=%h", bus3.dest_mac, C_BCAST); end
      total++; if (bus3.src_mac !== C_MAC1) begin bad++; $display("FAIL net21_src got=%h exp=%h", bus3.src_mac, C_MAC1); end
   endtask

   task automatic test_miss();
      logic [31:0] ips [2];
      ips[0] = 32'h0A00_1669;           // 10.0.22.105
      ips[1] = 32'h0A00_1769;           // 10.0.23.105
      for (int i = 0; i < 2; i++) begin
         pulse_req(1'b0, ips[i]);
         @(posedge clk); #1;
         total++; if (bus3.ack !== 1'b1) begin bad++; $display("FAIL miss%0d_ack got=%b exp=1", i, bus3.ack); end
         total++; if (bus3.forward_port !== 4'b0000) begin bad++; $display("FAIL miss%0d_port got=%b exp=0000", i, bus3.forward_port); end
         total++; if (bus3.src_mac !== 48'h0) begin bad++; $display("FAIL miss%0d_src got=%h exp=0", i, bus3.src_mac); end
         total++; if (bus3.dest_mac !== 48'h0) begin bad++; $display("FAIL miss%0d_dest got=%h exp=0", i, bus3.dest_mac); end
         total++; if (bus3.dest_ip !== ips[i]) begin bad++; $display("FAIL miss%0d_ip got=%h exp=%h", i, bus3.dest_ip, ips[i]); end
      end
   endtask

   task automatic test_back_to_back();
      @(posedge clk); #1;
      bus3.req = 1'b1; bus3.search_ip = 32'h0A00_1469;   // E0
      @(posedge clk); #1;
      bus3.search_ip = 32'h0A00_1569;                    // E2
      @(posedge clk); #1;
      bus3.search_ip = 32'h0A00_1669;                    // miss
      total++; if (bus3.ack !== 1'b1) begin bad++; $display("FAIL b2b_ack0 got=%b exp=1", bus3.ack); end
      total++; if (bus3.dest_mac !== 48'h001122334455) begin bad++; $display("FAIL b2b_dest0 got=%h exp=001122334455", bus3.dest_mac); end
      @(posedge clk); #1;
      bus3.req = 1'b0; bus3.search_ip = 32'hDEAD_BEEF;
      total++; if (bus3.ack !== 1'b1) begin bad++; $display("FAIL b2b_ack1 got=%b exp=1", bus3.ack); end
      total++; if (bus3.forward_port !== 4'b0010) begin bad++; $display("FAIL b2b_port1 got=%b exp=0010", bus3.forward_port); end
      total++; if (bus3.dest_mac !== 48'h0011223344aa) begin bad++; $display("FAIL b2b_dest1 got=%h exp=0011223344aa", bus3.dest_mac); end
      @(posedge clk); #1;
      total++; if (bus3.ack !== 1'b1) begin bad++; $display("FAIL b2b_ack2 got=%b exp=1", bus3.ack); end
      total++; if (bus3.forward_port !== 4'b0000) begin bad++; $display("FAIL b2b_port2 got=%b exp=0000", bus3.forward_port); end
      total++; if (bus3.dest_ip !== 32'h0A00_1669) begin bad++; $display("FAIL b2b_ip2 got=%h exp=0a001669", bus3.dest_ip); end
      @(posedge clk); #1;
      total++; if (bus3.ack !== 1'b0) begin bad++; $display("FAIL b2b_ack_end got=%b exp=0", bus3.ack); end
   endtask

   task automatic test_maxport();
      pulse_req(1'b1, 32'h0A00_1469);   // port 0 still valid with MAX_PORT=0
      @(posedge clk); #1;
      total++; if (bus0.forward_port !== 4'b0001) begin bad++; $display("FAIL mp0_e0_port got=%b exp=0001", bus0.forward_port); end
      total++; if (bus0.src_mac !== C_MAC0) begin bad++; $display("FAIL mp0_e0_src got=%h exp=%h", bus0.src_mac, C_MAC0); end
      pulse_req(1'b1, 32'h0A00_1569);   // port 1 masked away -> miss
      @(posedge clk); #1;
      total++; if (bus0.ack !== 1'b1) begin bad++; $display("FAIL mp0_ack got=%b exp=1", bus0.ack); end
      total++; if (bus0.forward_port !== 4'b0000) begin bad++; $display("FAIL mp0_port got=%b exp=0000", bus0.forward_port); end
      total++; if (bus0.src_mac !== 48'h0) begin bad++; $display("FAIL mp0_src got=%h exp=0", bus0.src_mac); end
      total++; if (bus0.dest_mac !== 48'h0) begin bad++; $display("FAIL mp0_dest got=%h exp=0", bus0.dest_mac); end
      total++; if (bus0.dest_ip !== 32'h0A00_1569) begin bad++; $display("FAIL mp0_ip got=%h exp=0a001569", bus0.dest_ip); end
   endtask

   task automatic test_reset_mid();
      pulse_req(1'b0, 32'h0A00_1469);   // request now in stage 1
      rst = 1'b1;
      #2;
      total++; if (bus3.dest_mac !== 48'h0) begin bad++; $display("FAIL rstmid_dest got=%h exp=0", bus3.dest_mac); end
      total++; if (bus3.forward_port !== 4'h0) begin bad++; $display("FAIL rstmid_port got=%b exp=0000", bus3.forward_port); end
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         total++; if (bus3.ack !== 1'b0) begin bad++; $display("FAIL rstmid_ack%0d got=%b exp=0", i, bus3.ack); end
      end
      total++; if (bus3.src_mac !== 48'h0) begin bad++; $display("FAIL rstmid_src got=%h exp=0", bus3.src_mac); end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      bus3.req = 1'b0; bus3.search_ip = 32'h0;
      bus0.req = 1'b0; bus0.search_ip = 32'h0;
      bus3.int_0_mac_addr = C_MAC0; bus3.int_1_mac_addr = C_MAC1;
      bus3.int_2_mac_addr = C_MAC2; bus3.int_3_mac_addr = C_MAC3;
      bus0.int_0_mac_addr = C_MAC0; bus0.int_1_mac_addr = C_MAC1;
      bus0.int_2_mac_addr = C_MAC2; bus0.int_3_mac_addr = C_MAC3;

      test_reset();
      test_subnet();
      test_host();
      test_priority();
      test_miss();
      test_back_to_back();
      test_maxport();
      test_reset_mid();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

`default_nettype wire
